// File: rtl/risc_pkg.sv
// Shared types for the VeriRISC sequencer: phase and opcode encodings,
// the phase count and the ALU-operation classifier.
package risc_pkg;

  localparam int NUM_PHASES = 8;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  typedef enum logic [2:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_t;

  // Opcodes that read an operand from memory and load the result into AC.
  function automatic logic is_aluop(input opcode_t op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/risc_ctl_decode.sv
// Combinational strobe decode from (phase, opcode, zero, halted).
// Once halted, every datapath strobe is forced low; only halt stays up.
module risc_ctl_decode
  import risc_pkg::*;
(
  input  phase_t  phase,
  input  opcode_t opcode,
  input  logic    zero,
  input  logic    halted,
  output logic    sel,
  output logic    rd,
  output logic    wr,
  output logic    ld_ir,
  output logic    ld_ac,
  output logic    ld_pc,
  output logic    inc_pc,
  output logic    data_e,
  output logic    halt
);

  logic aluop;
  logic is_sto;
  logic is_jmp;
  logic is_skz;

  assign aluop  = is_aluop(opcode);
  assign is_sto = (opcode == OP_STO);
  assign is_jmp = (opcode == OP_JMP);
  assign is_skz = (opcode == OP_SKZ);

  // halt is visible in OP_ADDR before the halted register actually sets.
  assign halt = halted | ((phase == OP_ADDR) && (opcode == OP_HLT));

  // Phase-by-phase strobe map; unlisted strobes stay at 0.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;
    ld_ir  = 1'b0;
    ld_ac  = 1'b0;
    ld_pc  = 1'b0;
    inc_pc = 1'b0;
    data_e = 1'b0;
    case (phase)
      INST_ADDR: begin
        sel = 1'b1;
      end
      INST_FETCH: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      INST_LOAD, IDLE: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      OP_ADDR: begin
        inc_pc = 1'b1;
      end
      OP_FETCH: begin
        rd = aluop;
      end
      ALU_OP: begin
        rd     = aluop;
        inc_pc = is_skz & zero;
        ld_pc  = is_jmp;
        data_e = is_sto;
      end
      STORE: begin
        rd     = aluop;
        ld_ac  = aluop;
        ld_pc  = is_jmp;
        wr     = is_sto;
        data_e = is_sto;
      end
      default: begin
        sel = 1'b0;
      end
    endcase
    if (halted) begin
      sel    = 1'b0;
      rd     = 1'b0;
      wr     = 1'b0;
      ld_ir  = 1'b0;
      ld_ac  = 1'b0;
      ld_pc  = 1'b0;
      inc_pc = 1'b0;
      data_e = 1'b0;
    end
  end

endmodule

// File: rtl/risc_sequencer.sv
// Eight-phase VeriRISC sequencer: phase counter plus sticky halted flag.
// en is a plain advance enable (no handshake): with en=1 and not halted the
// phase steps by one per clock; otherwise phase and strobes hold.
// The current phase is exported on `phase` for observation.
module risc_sequencer
  import risc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic [2:0] phase,
  output logic       sel,
  output logic       rd,
  output logic       wr,
  output logic       ld_ir,
  output logic       ld_ac,
  output logic       ld_pc,
  output logic       inc_pc,
  output logic       data_e,
  output logic       halt
);

  localparam logic [2:0] LAST_PHASE = 3'(NUM_PHASES - 1);

  phase_t  phase_q, phase_d;
  logic    halted_q, halted_d;
  opcode_t op;

  assign op    = opcode_t'(opcode);
  assign phase = phase_q;

  // Next phase and halted: step only when enabled and not halted; HLT seen
  // while leaving OP_ADDR freezes the counter at OP_FETCH.
  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    if (en && !halted_q) begin
      if (phase_q == LAST_PHASE) begin
        phase_d = INST_ADDR;
      end else begin
        phase_d = phase_t'(phase_q + 3'd1);
      end
      if ((phase_q == OP_ADDR) && (op == OP_HLT)) begin
        halted_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  risc_ctl_decode u_decode (
    .phase  (phase_q),
    .opcode (op),
    .zero   (zero),
    .halted (halted_q),
    .sel    (sel),
    .rd     (rd),
    .wr     (wr),
    .ld_ir  (ld_ir),
    .ld_ac  (ld_ac),
    .ld_pc  (ld_pc),
    .inc_pc (inc_pc),
    .data_e (data_e),
    .halt   (halt)
  );

endmodule

// File: doc/risc_sequencer.md
# risc_sequencer

Eight-phase instruction sequencer for the VeriRISC core. It advances a 3-bit phase counter and decodes the current phase, the instruction register opcode and the accumulator zero flag into the datapath control strobes. Those strobes are the memory/PC address mux select, memory read/write, IR/AC/PC load, PC increment and data-bus enable. It replaces the two-phase fetch/execute toggle as the single source of datapath sequencing and sits between the IR/ALU and the memory, PC, IR and AC registers.

## Interface
- NUM_PHASES, 8, phase count; fixed; any other value is illegal.
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  advance enable; phase holds when low
- opcode  in  3  IR[7:5]
- zero  in  1  accumulator-zero flag from the ALU
- phase  out  3  current phase
- sel  out  1  address mux: 1=PC, 0=IR operand
- rd  out  1  memory read
- wr  out  1  memory write
- ld_ir  out  1  load IR
- ld_ac  out  1  load AC
- ld_pc  out  1  load PC from IR operand
- inc_pc  out  1  increment PC
- data_e  out  1  drive AC onto data bus
- halt  out  1  core halted (sticky)

## Operation
- Phases, in order:
  - 0 INST_ADDR
  - 1 INST_FETCH
  - 2 INST_LOAD
  - 3 IDLE
  - 4 OP_ADDR
  - 5 OP_FETCH
  - 6 ALU_OP
  - 7 STORE
  - Then wrap 7 to 0.
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7. ALUOP = ADD|AND|XOR|LDA.
- Strobes are combinational from registered phase, opcode and zero. Every strobe not listed for a phase is 0.
  - INST_ADDR: sel.
  - INST_FETCH: sel, rd.
  - INST_LOAD: sel, rd, ld_ir.
  - IDLE: sel, rd, ld_ir.
  - OP_ADDR: inc_pc. The halted register sets when opcode==HLT.
  - OP_FETCH: rd=ALUOP.
  - ALU_OP: rd=ALUOP, inc_pc=SKZ&zero, ld_pc=JMP, data_e=STO.
  - STORE: rd=ALUOP, ld_ac=ALUOP, ld_pc=JMP, wr=STO, data_e=STO.
- Phase counter: advances by 1 (mod 8) on each clk edge with en=1 and halted=0; otherwise holds.
- Halted register:
  - Sets on the clk edge leaving OP_ADDR with opcode==HLT and en=1.
  - Once set, the phase counter freezes at OP_FETCH (5).
  - Cleared only by rst.
- halt output = halted | (phase==OP_ADDR & opcode==HLT).
- While halted, all strobes except halt are forced to 0.
- opcode and zero are sampled combinationally. Their stability is the datapath's responsibility: IR loads at IDLE, AC loads at STORE.

## Timing
- Reset (async, mid-phase included):
  - phase=0, halted=0.
  - Outputs: sel=1; rd=wr=ld_ir=ld_ac=ld_pc=inc_pc=data_e=halt=0.
- First edge after rst release with en=1: phase becomes 1. There is no extra hold cycle.
- One instruction = 8 enabled cycles.
- Strobe latency from phase change: zero cycles (combinational).
- en low freezes phase and strobes at their current values. Resuming continues from the held phase.
- Simultaneous en=0 in OP_ADDR with HLT: halted does not set until the next enabled edge. halt is still asserted combinationally.
- zero changing during ALU_OP changes inc_pc in the same cycle. The PC samples it on the edge ending ALU_OP.

## Structure
- Package risc_pkg holds:
  - phase_t enum, 3-bit, values 0-7 as named above.
  - opcode_t enum, 3-bit.
  - function is_aluop(opcode_t).
- Sub-module risc_ctl_decode: purely combinational map from (phase, opcode, zero, halted) to the strobes.
- The top contains only the phase counter and the halted register.

## Test plan
- Reset then 8 enabled cycles with opcode=ADD:
  - phase 0..7 then 0.
  - rd=1 in phases 1-3 and 5-7.
  - ld_ac=1 only in phase 7; wr=0 throughout.
- opcode=STO:
  - data_e=1 in phases 6-7; wr=1 only in phase 7.
  - rd=0 in phases 5-7.
- opcode=SKZ:
  - zero=1: inc_pc=1 in phases 4 and 6.
  - zero=0: inc_pc=1 only in phase 4.
- opcode=JMP: ld_pc=1 in phases 6-7; inc_pc=1 only in phase 4.
- opcode=HLT:
  - halt=1 in phase 4.
  - Phase sticks at 5 for 20 cycles with all other strobes 0.
  - rst returns phase=0, sel=1, halt=0.
- Control and reset disturbances:
  - en=0 for 3 cycles at phase 2: phase and strobes hold.
  - rst asserted mid-phase 6: phase=0 immediately, without waiting for clk.
